aes_128_axil_regfile: RTL and testbench

- AXI4-Lite slave register bank and control FSM between the processor interconnect and the AES-128 encryption core.
- Holds the 128-bit key and plaintext and starts the core.
- Captures the 128-bit ciphertext, reports busy/done status and raises a level interrupt.
- Registers are readable and writable through 32-bit AXI4-Lite accesses.

---
 rtl/aes_128_axil_pkg.sv | 30 +++
 rtl/aes_128_axil_if.sv | 79 +++++++
 rtl/aes_128_axil_regfile.sv | 141 ++++++++++++++
 tb/tb_aes_128_axil_regfile.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_axil_pkg.sv
// Shared register map, response codes and FSM state type for the AES-128 AXI4-Lite register bank.
// Pure definitions: no latency, no backpressure.
package aes_128_axil_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_KEY0   = 6'h10;
    localparam logic [5:0] ADDR_DIN0   = 6'h20;
    localparam logic [5:0] ADDR_DOUT0  = 6'h30;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_128_axil_if.sv
// AXI4-Lite slave handshake: one-cycle AW/W and AR ready pulses; register access on the accepting edge.
// B and R are registered one cycle later and held until BREADY/RREADY; no new access while a response is pending.
module aes_128_axil_if
    import aes_128_axil_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wvalid,
    output logic            wready,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [AW-1:0]   araddr,
    input  logic            arvalid,
    output logic            arready,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      rresp,
    output logic            rvalid,
    input  logic            rready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic [DW/8-1:0] wr_strb,
    input  logic            wr_err,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data
);

    logic aw_rdy;
    logic ar_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_rdy <= 1'b0;
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
            ar_rdy <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            aw_rdy <= awvalid & wvalid & ~bvalid & ~aw_rdy;
            // bvalid is always low while aw_rdy is high, so the two branches never collide
            if (aw_rdy) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            ar_rdy <= arvalid & ~rvalid & ~ar_rdy;
            if (ar_rdy) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign awready = aw_rdy;
    assign wready  = aw_rdy;
    assign arready = ar_rdy;
    assign rresp   = RESP_OKAY;
    assign wr_en   = aw_rdy;
    assign wr_addr = awaddr;
    assign wr_data = wdata;
    assign wr_strb = wstrb;
    assign rd_en   = ar_rdy;
    assign rd_addr = araddr;

endmodule

// File: rtl/aes_128_axil_regfile.sv
// AES-128 register bank + IDLE/RUN control: start pulse one cycle after the CTRL write, ciphertext captured on core_done.
// AXI backpressure handled in aes_128_axil_if; KEY/DIN writes and re-starts while busy answer SLVERR.
module aes_128_axil_regfile
    import aes_128_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    core_key,
    output logic [127:0]                    core_din,
    output logic                            core_start,
    input  logic [127:0]                    core_dout,
    input  logic                            core_done,
    output logic                            irq
);

    logic                            wr_en, wr_err, rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

    aes_128_axil_if #(.AW(C_S_AXI_ADDR_WIDTH), .DW(C_S_AXI_DATA_WIDTH)) u_if (
        .clk(ACLK), .rst(ARESET),
        .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
        .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
        .bresp(S_AXI_BRESP), .bvalid(S_AXI_BVALID), .bready(S_AXI_BREADY),
        .araddr(S_AXI_ARADDR), .arvalid(S_AXI_ARVALID), .arready(S_AXI_ARREADY),
        .rdata(S_AXI_RDATA), .rresp(S_AXI_RRESP), .rvalid(S_AXI_RVALID), .rready(S_AXI_RREADY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    logic [31:0] key  [4];
    logic [31:0] din  [4];
    logic [31:0] dout [4];
    logic        irq_en, done, busy, start_req, start_acc;
    state_t      state_q, state_d;

    logic [3:0] wr_word, rd_word;
    logic       wr_ctrl, wr_stat, wr_key, wr_din;
    logic       unused_addr_lsb;

    assign wr_word = wr_addr[5:2];
    assign rd_word = rd_addr[5:2];
    assign wr_ctrl = (wr_word == ADDR_CTRL[5:2]);
    assign wr_stat = (wr_word == ADDR_STATUS[5:2]);
    assign wr_key  = (wr_addr[5:4] == ADDR_KEY0[5:4]);
    assign wr_din  = (wr_addr[5:4] == ADDR_DIN0[5:4]);
    assign unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

    assign busy      = (state_q == RUN);
    assign start_req = wr_en & wr_ctrl & wr_strb[0] & wr_data[CTRL_START];
    assign wr_err    = busy & (wr_key | wr_din | (wr_ctrl & wr_strb[0] & wr_data[CTRL_START]));

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: if (start_req) begin
                state_d   = RUN;
                start_acc = 1'b1;
            end
            RUN:  if (core_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            core_start <= 1'b0;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                key[i]  <= '0;
                din[i]  <= '0;
                dout[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            core_start <= start_acc;
            if (wr_en && !busy && wr_key)
                key[wr_word[1:0]] <= apply_strb(key[wr_word[1:0]], wr_data, wr_strb);
            if (wr_en && !busy && wr_din)
                din[wr_word[1:0]] <= apply_strb(din[wr_word[1:0]], wr_data, wr_strb);
            if (wr_en && wr_ctrl && wr_strb[0])
                irq_en <= wr_data[CTRL_IRQ_EN];
            // completion beats a simultaneous write-1-to-clear
            if (busy && core_done)
                done <= 1'b1;
            else if (start_acc)
                done <= 1'b0;
            else if (wr_en && wr_stat && wr_strb[0] && wr_data[STAT_DONE])
                done <= 1'b0;
            if (busy && core_done)
                for (int i = 0; i < 4; i++)
                    dout[i] <= core_dout[127-32*i -: 32];
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            if (rd_word == ADDR_CTRL[5:2])
                rd_data[CTRL_IRQ_EN] = irq_en;
            else if (rd_word == ADDR_STATUS[5:2]) begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done;
            end else if (rd_addr[5:4] == ADDR_KEY0[5:4])
                rd_data = key[rd_word[1:0]];
            else if (rd_addr[5:4] == ADDR_DIN0[5:4])
                rd_data = din[rd_word[1:0]];
            else if (rd_addr[5:4] == ADDR_DOUT0[5:4])
                rd_data = dout[rd_word[1:0]];
        end
    end

    assign core_key = {key[0], key[1], key[2], key[3]};
    assign core_din = {din[0], din[1], din[2], din[3]};
    assign irq      = done & irq_en;

endmodule

// File: tb/tb_aes_128_axil_regfile.sv
// Directed bench for the AES-128 AXI4-Lite register bank with a 10-cycle core model and response scoreboards.
module tb_aes_128_axil_regfile;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] core_key, core_din, core_dout;
    logic         core_start, core_done, irq;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 ACLK = ~ACLK;

    aes_128_axil_regfile dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .core_key(core_key), .core_din(core_din), .core_start(core_start),
        .core_dout(core_dout), .core_done(core_done), .irq(irq)
    );

    // core model: done pulse 10 cycles after each start; the main sequence can also inject a pulse
    logic model_en = 1'b0;
    logic model_done = 1'b0;
    logic man_done = 1'b0;
    int   starts = 0;
    int   cnt = 0;
    assign core_done = model_done | man_done;
    assign core_dout = CT;

    initial begin
        forever begin
            @(negedge ACLK);
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_done = 1'b1;
            end
            if (core_start) begin
                starts++;
                if (model_en) cnt = 10;
            end
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] rd_q[$];
    logic [1:0]  b_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input int hold, input bit inject);
        int n;
        logic [1:0] e;
        b_q.push_back(er);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_AWREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_AWREADY) tmo("aw_timeout");
        if (inject) man_done = 1'b1;
        @(negedge ACLK);
        man_done = 1'b0;
        e = b_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("b_hold", {S_AXI_AWREADY, S_AXI_BVALID, S_AXI_BRESP}, {1'b0, 1'b1, e});
            @(negedge ACLK);
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("bvalid", S_AXI_BVALID, 1'b1);
        chk("bresp", S_AXI_BRESP, e);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input int hold, input string tag);
        int n;
        logic [31:0] e;
        rd_q.push_back(exp);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_ARREADY) tmo("ar_timeout");
        @(negedge ACLK);
        e = rd_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("r_hold", {S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b0, 1'b1, 2'b00, e});
            @(negedge ACLK);
        end
        S_AXI_ARVALID = 1'b0;
        chk("rvalid_rresp", {S_AXI_RVALID, S_AXI_RRESP}, {1'b1, 2'b00});
        chk(tag, S_AXI_RDATA, e);
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        int s0;
        logic [127:0] kv, pv, cv;
        kv = KEY; pv = PT; cv = CT;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (5) @(negedge ACLK);
        ARESET = 1'b0;

        chk("rst_irq", irq, 1'b0);
        chk("rst_hs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, core_start}, 6'b0);
        chk("rst_rdata", {S_AXI_RDATA, S_AXI_RRESP}, 34'b0);
        for (int i = 0; i < 16; i++) axi_read(6'(4*i), 32'h0, 0, "rst_read");

        // FIPS-197 vector
        for (int i = 0; i < 4; i++) axi_write(6'(16 + 4*i), kv[127-32*i -: 32], 4'hF, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) axi_write(6'(32 + 4*i), pv[127-32*i -: 32], 4'hF, 2'b00, 0, 0);
        chk("core_key", core_key, KEY);
        chk("core_din", core_din, PT);
        model_en = 1'b1;
        s0 = starts;
        axi_write(6'h00, 32'h3, 4'hF, 2'b00, 0, 0);
        axi_read(6'h04, 32'h1, 0, "status_run");
        repeat (20) @(negedge ACLK);
        chk("one_start", 32'(starts - s0), 32'd1);
        axi_read(6'h04, 32'h2, 0, "status_done");
        for (int i = 0; i < 4; i++) axi_read(6'(48 + 4*i), cv[127-32*i -: 32], 0, "dout");
        chk("irq_done", irq, 1'b1);
        axi_read(6'h00, 32'h2, 0, "ctrl_rd");

        // DONE write-1-to-clear
        axi_write(6'h04, 32'h2, 4'hF, 2'b00, 0, 0);
        axi_read(6'h04, 32'h0, 0, "status_w1c");
        chk("irq_w1c", irq, 1'b0);

        // byte strobes
        axi_write(6'h24, 32'hAABBCCDD, 4'b0010, 2'b00, 0, 0);
        axi_read(6'h24, 32'h4455CC77, 0, "din1_strb");

        // writes while busy; core never finishes on its own here
        model_en = 1'b0;
        s0 = starts;
        axi_write(6'h00, 32'h1, 4'hF, 2'b00, 0, 0);
        axi_read(6'h04, 32'h1, 0, "status_busy");
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, 2'b10, 0, 0);
        axi_read(6'h10, 32'h00010203, 0, "key0_kept");
        axi_write(6'h00, 32'h3, 4'hF, 2'b10, 0, 0);
        repeat (3) @(negedge ACLK);
        chk("no_restart", 32'(starts - s0), 32'd1);
        axi_read(6'h00, 32'h2, 0, "irq_en_busy");

        // W1C on the same edge as core_done: set wins
        axi_write(6'h04, 32'h2, 4'hF, 2'b00, 0, 1);
        axi_read(6'h04, 32'h2, 0, "done_wins");
        chk("irq_same_edge", irq, 1'b1);

        // backpressure on B and R
        axi_write(6'h28, 32'h12345678, 4'hF, 2'b00, 20, 0);
        axi_read(6'h28, 32'h12345678, 20, "din2_bp");

        // reset mid-run with responses in flight, then a late core_done
        model_en = 1'b1;
        axi_write(6'h00, 32'h1, 4'hF, 2'b00, 0, 0);
        repeat (2) @(negedge ACLK);
        S_AXI_AWADDR = 6'h20; S_AXI_WDATA = 32'h11111111; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("inflight", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        ARESET = 1'b1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        chk("mid_rst_out", {S_AXI_BVALID, S_AXI_RVALID, core_start, irq}, 4'b0);
        repeat (15) @(negedge ACLK);
        for (int i = 0; i < 16; i++) axi_read(6'(4*i), 32'h0, 0, "post_rst_read");
        chk("post_rst_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
